// File: rtl/task_dispatcher.sv
// Task FIFO consumer: decodes push/pop task words and issues them to the PIFO trees.
// Per-tree occupancy counters drop pushes to full trees and pops from empty ones.
module task_dispatcher #(
  parameter int PTW           = 16,
  parameter int MTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int TREE_CAP      = 1024,
  parameter int CNT_W         = $clog2(TREE_CAP+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dispatch_en,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [PTW+MTW+TREE_NUM_BITS:0] fifo_dout,
  input  logic [TREE_NUM-1:0]           tree_ready,
  output logic                          tree_push,
  output logic                          tree_pop,
  output logic [TREE_NUM_BITS-1:0]      tree_id,
  output logic [PTW+MTW-1:0]            tree_push_data,
  output logic                          drop_ovf,
  output logic                          drop_unf,
  output logic                          drop_bad_id,
  output logic [TREE_NUM*CNT_W-1:0]     occupancy
);

  localparam int DW = PTW + MTW;
  localparam int W  = DW + TREE_NUM_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  state_t                   state;
  logic                     hold_op;
  logic [TREE_NUM_BITS-1:0] hold_id;
  logic [DW-1:0]            hold_data;
  logic [CNT_W-1:0]         cnt [TREE_NUM];

  logic             in_issue;
  logic             id_ok;
  logic [CNT_W-1:0] cur_cnt;
  logic             rdy;
  logic             is_full;
  logic             is_empty;
  logic             fire;
  logic             retire;
  logic             can_rd;

  // Every output is gated by rst_n so nothing escapes during reset.
  always_comb begin
    in_issue       = rst_n && (state == ISSUE);
    id_ok          = int'(hold_id) < TREE_NUM;
    cur_cnt        = id_ok ? cnt[hold_id] : '0;
    rdy            = id_ok && tree_ready[hold_id];
    is_full        = cur_cnt == CNT_W'(TREE_CAP);
    is_empty       = cur_cnt == '0;
    drop_bad_id    = in_issue && !id_ok;
    drop_ovf       = in_issue && id_ok && hold_op && is_full;
    drop_unf       = in_issue && id_ok && !hold_op && is_empty;
    fire           = in_issue && id_ok && rdy &&
                     !(hold_op ? is_full : is_empty);
    retire         = drop_bad_id || drop_ovf || drop_unf || fire;
    can_rd         = rst_n && dispatch_en && !fifo_empty;
    fifo_rd_en     = can_rd && ((state == IDLE) || retire);
    tree_push      = fire && hold_op;
    tree_pop       = fire && !hold_op;
    tree_id        = fire ? hold_id : '0;
    tree_push_data = tree_push ? hold_data : '0;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < TREE_NUM; i++)
      occupancy[i*CNT_W +: CNT_W] = cnt[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_op   <= 1'b0;
      hold_id   <= '0;
      hold_data <= '0;
      for (int i = 0; i < TREE_NUM; i++)
        cnt[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_rd_en)
            state <= FETCH;
        end
        FETCH: begin
          hold_op   <= fifo_dout[W-1];
          hold_id   <= fifo_dout[W-2 -: TREE_NUM_BITS];
          hold_data <= fifo_dout[DW-1:0];
          state     <= ISSUE;
        end
        ISSUE: begin
          if (retire)
            state <= fifo_rd_en ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < TREE_NUM; i++)
        if (fire && int'(hold_id) == i)
          cnt[i] <= hold_op ? cnt[i] + CNT_W'(1)
                            : cnt[i] - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: default instance plus a
// small instance (3 trees, capacity 2) for overflow and bad-id drops.
module tb_task_dispatcher;

  localparam int PTW = 16;
  localparam int MTW = 16;
  localparam int TB  = 2;
  localparam int DW  = PTW + MTW;
  localparam int W   = DW + TB + 1;
  localparam int CW  = 11;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // main instance
  logic            dispatch_en = 1'b0;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [W-1:0]    fifo_dout = '0;
  logic [3:0]      tree_ready = '1;
  logic            tree_push, tree_pop;
  logic [TB-1:0]   tree_id;
  logic [DW-1:0]   tree_push_data;
  logic            drop_ovf, drop_unf, drop_bad_id;
  logic [4*CW-1:0] occupancy;

  logic [W-1:0] fmem [64];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_dout <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end

  task_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .tree_ready(tree_ready),
    .tree_push(tree_push), .tree_pop(tree_pop),
    .tree_id(tree_id), .tree_push_data(tree_push_data),
    .drop_ovf(drop_ovf), .drop_unf(drop_unf),
    .drop_bad_id(drop_bad_id), .occupancy(occupancy)
  );

  // small instance
  logic             dispatch_en2 = 1'b0;
  logic             fifo_empty2;
  logic             fifo_rd_en2;
  logic [W-1:0]     fifo_dout2 = '0;
  logic [2:0]       tree_ready2 = '1;
  logic             tree_push2, tree_pop2;
  logic [TB-1:0]    tree_id2;
  logic [DW-1:0]    tree_push_data2;
  logic             drop_ovf2, drop_unf2, drop_bad_id2;
  logic [3*CW2-1:0] occupancy2;

  logic [W-1:0] fmem2 [16];
  int           wr_ptr2 = 0;
  int           rd_ptr2 = 0;
  assign fifo_empty2 = (rd_ptr2 == wr_ptr2);
  always @(posedge clk)
    if (fifo_rd_en2) begin
      fifo_dout2 <= fmem2[rd_ptr2];
      rd_ptr2    <= rd_ptr2 + 1;
    end

  task_dispatcher #(.TREE_NUM(3), .TREE_CAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en2),
    .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
    .fifo_dout(fifo_dout2), .tree_ready(tree_ready2),
    .tree_push(tree_push2), .tree_pop(tree_pop2),
    .tree_id(tree_id2), .tree_push_data(tree_push_data2),
    .drop_ovf(drop_ovf2), .drop_unf(drop_unf2),
    .drop_bad_id(drop_bad_id2), .occupancy(occupancy2)
  );

  function automatic logic [W-1:0] mk(input logic op,
                                      input logic [TB-1:0] id,
                                      input logic [DW-1:0] data);
    return {op, id, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic put2(input logic [W-1:0] w);
    fmem2[wr_ptr2] = w;
    wr_ptr2 = wr_ptr2 + 1;
  endtask

  function automatic logic [CW-1:0] occ(input int i);
    return occupancy[i*CW +: CW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total_cnt++;
    if ({fifo_rd_en, tree_push, tree_pop} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000",
               {fifo_rd_en, tree_push, tree_pop});
    else pass_cnt++;
    total_cnt++;
    if ({tree_id, tree_push_data, drop_ovf, drop_unf, drop_bad_id} !== '0)
      $display("FAIL reset_bus got id=%0d data=%h drops=%b want 0",
               tree_id, tree_push_data, {drop_ovf, drop_unf, drop_bad_id});
    else pass_cnt++;
    total_cnt++;
    if (occupancy !== '0 || occupancy2 !== '0)
      $display("FAIL reset_occ got %h/%h want 0", occupancy, occupancy2);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_push_basic();
    put(mk(1'b1, 2'd2, 32'hABCD_1234));
    dispatch_en = 1'b1;
    #1;
    total_cnt++;
    if (fifo_rd_en !== 1'b1)
      $display("FAIL push_rd got %b want 1", fifo_rd_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fifo_rd_en !== 1'b0 || tree_push !== 1'b0)
      $display("FAIL push_fetch got rd=%b push=%b want 0 0",
               fifo_rd_en, tree_push);
    else pass_cnt++;
    step();
    total_cnt++;
    if (tree_push !== 1'b1 || tree_pop !== 1'b0)
      $display("FAIL push_strobe got push=%b pop=%b want 1 0",
               tree_push, tree_pop);
    else pass_cnt++;
    total_cnt++;
    if (tree_id !== 2'd2 || tree_push_data !== 32'hABCD_1234)
      $display("FAIL push_bus got id=%0d data=%h want 2 abcd1234",
               tree_id, tree_push_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (occ(2) !== 11'd1 || tree_push !== 1'b0 || tree_push_data !== '0)
      $display("FAIL push_occ got occ2=%0d push=%b data=%h want 1 0 0",
               occ(2), tree_push, tree_push_data);
    else pass_cnt++;
  endtask

  task automatic test_pop_underflow();
    put(mk(1'b0, 2'd1, 32'h0000_FFFF));
    #1;
    step();
    step();
    total_cnt++;
    if (drop_unf !== 1'b1 || tree_pop !== 1'b0 || tree_id !== 2'd0)
      $display("FAIL unf_pulse got unf=%b pop=%b id=%0d want 1 0 0",
               drop_unf, tree_pop, tree_id);
    else pass_cnt++;
    total_cnt++;
    if (drop_ovf !== 1'b0 || drop_bad_id !== 1'b0)
      $display("FAIL unf_other got ovf=%b bad=%b want 0 0",
               drop_ovf, drop_bad_id);
    else pass_cnt++;
    step();
    total_cnt++;
    if (drop_unf !== 1'b0)
      $display("FAIL unf_width got %b want 0", drop_unf);
    else pass_cnt++;
    total_cnt++;
    if (occ(1) !== 11'd0 || occ(2) !== 11'd1)
      $display("FAIL unf_occ got occ1=%0d occ2=%0d want 0 1",
               occ(1), occ(2));
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    tree_ready = 4'b1110;
    put(mk(1'b1, 2'd0, 32'h0000_55AA));
    put(mk(1'b1, 2'd0, 32'h0000_0002));
    #1;
    total_cnt++;
    if (fifo_rd_en !== 1'b1)
      $display("FAIL bp_rd got %b want 1", fifo_rd_en);
    else pass_cnt++;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (tree_push || tree_pop || fifo_rd_en) bad++;
      step();
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL bp_stall got %0d active stall cycles want 0", bad);
    else pass_cnt++;
    tree_ready = 4'b1111;
    #1;
    total_cnt++;
    if (tree_push !== 1'b1 || tree_id !== 2'd0 ||
        tree_push_data !== 32'h0000_55AA)
      $display("FAIL bp_strobe got push=%b id=%0d data=%h want 1 0 55aa",
               tree_push, tree_id, tree_push_data);
    else pass_cnt++;
    total_cnt++;
    if (fifo_rd_en !== 1'b1)
      $display("FAIL bp_reread got %b want 1", fifo_rd_en);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (tree_push !== 1'b1 || tree_push_data !== 32'h0000_0002)
      $display("FAIL bp_second got push=%b data=%h want 1 2",
               tree_push, tree_push_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (occ(0) !== 11'd2)
      $display("FAIL bp_occ got %0d want 2", occ(0));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int pat_bad;
    int data_bad;
    pat_bad = 0;
    data_bad = 0;
    for (int i = 0; i < 8; i++)
      put(mk(1'b1, 2'd3, 32'h3000_0000 + 32'(i)));
    #1;
    for (int k = 0; k < 18; k++) begin
      if (tree_push !== (k >= 2 && k <= 16 && k % 2 == 0)) pat_bad++;
      if (tree_push &&
          (tree_push_data !== 32'h3000_0000 + 32'(k/2 - 1) ||
           tree_id !== 2'd3))
        data_bad++;
      step();
    end
    total_cnt++;
    if (pat_bad !== 0)
      $display("FAIL b2b_pattern got %0d wrong cycles want 0", pat_bad);
    else pass_cnt++;
    total_cnt++;
    if (data_bad !== 0)
      $display("FAIL b2b_data got %0d wrong strobes want 0", data_bad);
    else pass_cnt++;
    total_cnt++;
    if (occ(3) !== 11'd8)
      $display("FAIL b2b_occ got %0d want 8", occ(3));
    else pass_cnt++;
  endtask

  task automatic test_cap();
    int pushes;
    int ovf_at;
    int bad_at;
    pushes = 0;
    ovf_at = -1;
    bad_at = -1;
    put2(mk(1'b1, 2'd0, 32'h1));
    put2(mk(1'b1, 2'd0, 32'h2));
    put2(mk(1'b1, 2'd0, 32'h3));
    put2(mk(1'b1, 2'd3, 32'h4));
    dispatch_en2 = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (tree_push2) pushes++;
      if (drop_ovf2) ovf_at = (ovf_at == -1) ? k : 99;
      if (drop_bad_id2) bad_at = (bad_at == -1) ? k : 99;
      step();
    end
    total_cnt++;
    if (pushes !== 2)
      $display("FAIL cap_pushes got %0d want 2", pushes);
    else pass_cnt++;
    total_cnt++;
    if (ovf_at !== 6)
      $display("FAIL cap_ovf got cycle %0d want 6", ovf_at);
    else pass_cnt++;
    total_cnt++;
    if (bad_at !== 8)
      $display("FAIL cap_bad_id got cycle %0d want 8", bad_at);
    else pass_cnt++;
    total_cnt++;
    if (occupancy2 !== 6'd2)
      $display("FAIL cap_occ got %h want 02", occupancy2);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_fetch();
    int act;
    act = 0;
    put(mk(1'b1, 2'd1, 32'hDEAD_BEEF));
    #1;
    total_cnt++;
    if (fifo_rd_en !== 1'b1)
      $display("FAIL rf_rd got %b want 1", fifo_rd_en);
    else pass_cnt++;
    step();
    rst_n = 1'b0;
    dispatch_en = 1'b0;
    step();
    total_cnt++;
    if ({fifo_rd_en, tree_push, tree_pop, drop_ovf, drop_unf,
         drop_bad_id} !== 6'b0 || tree_id !== '0 ||
        tree_push_data !== '0)
      $display("FAIL rf_outputs got rd=%b push=%b pop=%b data=%h want 0",
               fifo_rd_en, tree_push, tree_pop, tree_push_data);
    else pass_cnt++;
    total_cnt++;
    if (occupancy !== '0)
      $display("FAIL rf_occ got %h want 0", occupancy);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (tree_push || tree_pop || fifo_rd_en) act++;
      step();
    end
    total_cnt++;
    if (act !== 0 || occupancy !== '0)
      $display("FAIL rf_no_issue got %0d strobes occ=%h want 0 0",
               act, occupancy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_pop_underflow();
    test_backpressure();
    test_back_to_back();
    test_cap();
    test_reset_in_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Consumer side of the task FIFO that sits in front of the PIFO trees. It pops one task word at a time from the FIFO, decodes the push/pop opcode, tree ID and push payload, and waits until the target tree is ready. It then issues the operation as a single-cycle strobe on the shared tree command bus. It keeps per-tree occupancy counters so that it never issues a pop to an empty tree or a push to a full one.

## Interface
- PTW, 16, payload data width
- MTW, 16, metadata width
- TREE_NUM, 4, number of PIFO trees
- TREE_NUM_BITS, $clog2(TREE_NUM), tree ID width (must be ≥1)
- TREE_CAP, 1024, max elements per tree
- CNT_W, $clog2(TREE_CAP+1), occupancy counter width
- Derived: W = PTW+MTW+TREE_NUM_BITS+1 (task word width)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- dispatch_en  in  1  permits new FIFO reads; an already-held task is still issued
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- fifo_dout  in  W  FIFO read data, valid the cycle after fifo_rd_en
- tree_ready  in  TREE_NUM  per-tree ready to accept a command this cycle
- tree_push  out  1  push strobe
- tree_pop  out  1  pop strobe
- tree_id  out  TREE_NUM_BITS  target tree of the current strobe
- tree_push_data  out  PTW+MTW  push payload; 0 when tree_push=0
- drop_ovf  out  1  one-cycle pulse: push dropped, tree full
- drop_unf  out  1  one-cycle pulse: pop dropped, tree empty
- drop_bad_id  out  1  one-cycle pulse: tree ID ≥ TREE_NUM
- occupancy  out  TREE_NUM*CNT_W  packed per-tree counters; tree i at [i*CNT_W +: CNT_W]

## Operation
- Task word decode:
  - bit W-1 is the opcode: 1 = push, 0 = pop.
  - bits [W-2 : PTW+MTW] are the tree ID.
  - bits [PTW+MTW-1 : 0] are the payload. The payload is ignored for pops.
- FSM states IDLE, FETCH, ISSUE:
  - IDLE: if dispatch_en && !fifo_empty, drive fifo_rd_en=1 and go to FETCH. Otherwise stay in IDLE.
  - FETCH: register fifo_dout into the hold register (op, id, data) and go to ISSUE. fifo_rd_en=0.
  - ISSUE: the hold task is validated first, in this priority order:
    1. bad id → pulse drop_bad_id.
    2. push && occupancy[id]==TREE_CAP → pulse drop_ovf.
    3. pop && occupancy[id]==0 → pulse drop_unf.
  - A dropped task is retired in the same cycle; the drop pulse is driven combinationally in ISSUE.
  - Otherwise, if tree_ready[id] is high, drive tree_push or tree_pop combinationally from the hold register for exactly that cycle and retire the task. If tree_ready[id] is low, stay in ISSUE with all strobes low.
  - On retire: if dispatch_en && !fifo_empty, assert fifo_rd_en in the same cycle and go to FETCH. Otherwise go to IDLE.
- fifo_rd_en is asserted only in IDLE or on the retire cycle, and never when fifo_empty=1.
- At most one command strobe per cycle; tree_push and tree_pop are never high together.
- tree_id and tree_push_data are 0 whenever neither strobe is high.
- Occupancy counters:
  - An issued push increments occupancy[id]; an issued pop decrements it. Both update on the clock edge after the strobe.
  - Dropped tasks leave the counters unchanged.
  - Counters saturate at TREE_CAP and 0 by construction; no wrap-around is possible.
- dispatch_en falling while in FETCH or ISSUE does not cancel the held task. Only the next read is suppressed.

## Timing
- Reset (rst_n=0 at a clock edge) sets:
  - state to IDLE and the hold register to 0;
  - all occupancy counters to 0;
  - all outputs to 0.
- A read in flight at reset is discarded. The FIFO resets separately.
- Minimum latency: fifo_rd_en at cycle t, capture at t+1, strobe at t+2 (with tree_ready high).
- Peak throughput is one task per 2 cycles, because a retire at t re-reads at t and issues at t+2.
- Backpressure: the strobe is delayed by N cycles when tree_ready[id] is low for N cycles. No FIFO reads occur during the stall.
- The occupancy output reflects the registered counters: it updates 1 cycle after the strobe.
- Drop pulses are 1 cycle wide and coincide with the ISSUE cycle of the dropped task.

## Test plan
- Reset, then FIFO delivers push {1, id=2, data=0xABCD_1234} with tree_ready=all 1 → fifo_rd_en at t, tree_push=1 / tree_id=2 / data=0xABCD1234 at t+2, occupancy[2]=1 at t+3.
- Pop to tree 1 with occupancy 0 → drop_unf pulse at t+2; no tree_pop strobe; occupancy unchanged.
- Push to tree 0 while tree_ready[0]=0 for 5 cycles → tree_push held off 5 cycles, single strobe on the 6th ISSUE cycle; no extra fifo_rd_en during the stall.
- 8 back-to-back pushes to tree 3, FIFO never empty → strobes on alternate cycles; occupancy[3]=8.
- With TREE_CAP=2: 3 pushes to tree 0 → 2 strobes and 1 drop_ovf.
- rst_n low on the FETCH cycle → next cycle all outputs 0, state IDLE; the held task is never issued and the counters are zero.
